// File: rtl/rvv_backend_pkg.sv
// Shared mask-unit types and constants for the vector backend.
// No logic; constants only.
// Backpressure: not applicable.
package rvv_backend_pkg;

    localparam int VIOTA_BEAT_ELEMS = 64;
    localparam int VIOTA_LOCAL_W    = $clog2(VIOTA_BEAT_ELEMS) + 1;
    localparam int VLEN_DEFAULT     = 512;
    localparam int VIOTA_CNT_W      = $clog2(VLEN_DEFAULT) + 1;

    typedef logic [VIOTA_CNT_W-1:0]   viota_cnt_t;
    typedef logic [VIOTA_LOCAL_W-1:0] viota_local_t;

    typedef enum logic {
        VIOTA_IDLE = 1'b0,
        VIOTA_RUN  = 1'b1
    } viota_state_e;

endpackage

// File: rtl/rvv_backend_alu_unit_mask_viota64.sv
// Exclusive prefix popcount (viota) over one 64-bit active-element window.
// Latency: combinational.
// Backpressure: none.
module rvv_backend_alu_unit_mask_viota64
    import rvv_backend_pkg::*;
(
    input  logic [VIOTA_BEAT_ELEMS-1:0]               act,
    output logic [VIOTA_BEAT_ELEMS*VIOTA_LOCAL_W-1:0] viota,
    output viota_local_t                              popcnt
);

    viota_local_t acc;

    always_comb begin
        viota = '0;
        acc   = '0;
        for (int i = 0; i < VIOTA_BEAT_ELEMS; i++) begin
            viota[i*VIOTA_LOCAL_W +: VIOTA_LOCAL_W] = acc;
            acc = acc + viota_local_t'(act[i]);
        end
        popcnt = acc;
    end

endmodule

// File: rtl/rvv_backend_alu_mask_viota_seq.sv
// Sequences viota.m/vcpop.m over a VLEN mask, one 64-element beat per handshake.
// Latency: first beat one cycle after command accept; back-to-back commands with no bubble.
// Backpressure: beat outputs held while beat_ready is low; cmd_ready only when idle or on the last-beat handshake.
module rvv_backend_alu_mask_viota_seq
    import rvv_backend_pkg::*;
#(
    parameter  int VLEN   = VLEN_DEFAULT,
    parameter  int TAG_W  = 5,
    localparam int BEATS  = VLEN / VIOTA_BEAT_ELEMS,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int CNT_W  = $clog2(VLEN) + 1,
    localparam int VL_W   = $clog2(VLEN) + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [VLEN-1:0]                   cmd_vs2,
    input  logic [VLEN-1:0]                   cmd_v0,
    input  logic                              cmd_vm,
    input  logic [VL_W-1:0]                   cmd_vl,
    input  logic [TAG_W-1:0]                  cmd_tag,
    output logic                              beat_valid,
    input  logic                              beat_ready,
    output logic [BEAT_W-1:0]                 beat_idx,
    output logic [VIOTA_BEAT_ELEMS*CNT_W-1:0] beat_result,
    output logic [VIOTA_BEAT_ELEMS-1:0]       beat_elem_en,
    output logic                              beat_last,
    output logic [CNT_W-1:0]                  beat_total,
    output logic [TAG_W-1:0]                  beat_tag,
    output logic                              busy
);

    viota_state_e          state_q, state_d;
    logic [VLEN-1:0]       vs2_q, vs2_d;
    logic [VLEN-1:0]       v0_q, v0_d;
    logic                  vm_q, vm_d;
    logic [VL_W-1:0]       vl_q, vl_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CNT_W-1:0]      base_q, base_d;

    logic [VIOTA_BEAT_ELEMS-1:0]               vs2_win, v0_win, elem_en, act;
    logic [VIOTA_BEAT_ELEMS*VIOTA_LOCAL_W-1:0] viota;
    viota_local_t                              popcnt;
    logic [VL_W-1:0]                           last_idx;
    logic                                      is_last, hs, accept;

    assign vs2_win = vs2_q[{beat_q, 6'd0} +: VIOTA_BEAT_ELEMS];
    assign v0_win  = v0_q[{beat_q, 6'd0} +: VIOTA_BEAT_ELEMS];

    // Tail elements (global index >= vl) and masked-off elements are neither written nor counted.
    always_comb begin
        elem_en = '0;
        for (int i = 0; i < VIOTA_BEAT_ELEMS; i++) begin
            elem_en[i] = (VL_W'({beat_q, 6'(i)}) < vl_q) & (vm_q | v0_win[i]);
        end
    end

    assign act = elem_en & vs2_win;

    rvv_backend_alu_unit_mask_viota64 u_viota64 (
        .act    (act),
        .viota  (viota),
        .popcnt (popcnt)
    );

    // vl=0 still produces a single (empty) beat.
    assign last_idx = (vl_q == '0) ? '0 : ((vl_q - VL_W'(1)) >> 6);
    assign is_last  = (VL_W'(beat_q) == last_idx);

    assign beat_valid = (state_q == VIOTA_RUN);
    assign busy       = (state_q == VIOTA_RUN);
    assign hs         = beat_valid & beat_ready;
    assign cmd_ready  = ~flush & ((state_q == VIOTA_IDLE) | (hs & is_last));
    assign accept     = cmd_valid & cmd_ready;

    always_comb begin
        beat_result = '0;
        for (int i = 0; i < VIOTA_BEAT_ELEMS; i++) begin
            beat_result[i*CNT_W +: CNT_W] = base_q + CNT_W'(viota[i*VIOTA_LOCAL_W +: VIOTA_LOCAL_W]);
        end
    end

    assign beat_idx     = beat_q;
    assign beat_elem_en = elem_en;
    assign beat_last    = is_last;
    assign beat_total   = base_q + CNT_W'(popcnt);
    assign beat_tag     = tag_q;

    always_comb begin
        state_d = state_q;
        vs2_d   = vs2_q;
        v0_d    = v0_q;
        vm_d    = vm_q;
        vl_d    = vl_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        base_d  = base_q;
        if (flush) begin
            state_d = VIOTA_IDLE;
            beat_d  = '0;
            base_d  = '0;
        end else if (accept) begin
            state_d = VIOTA_RUN;
            vs2_d   = cmd_vs2;
            v0_d    = cmd_v0;
            vm_d    = cmd_vm;
            vl_d    = cmd_vl;
            tag_d   = cmd_tag;
            beat_d  = '0;
            base_d  = '0;
        end else if (hs) begin
            if (is_last) begin
                state_d = VIOTA_IDLE;
                beat_d  = '0;
                base_d  = '0;
            end else begin
                beat_d  = beat_q + BEAT_W'(1);
                base_d  = beat_total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= VIOTA_IDLE;
            vs2_q   <= '0;
            v0_q    <= '0;
            vm_q    <= 1'b0;
            vl_q    <= '0;
            tag_q   <= '0;
            beat_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            vs2_q   <= vs2_d;
            v0_q    <= v0_d;
            vm_q    <= vm_d;
            vl_q    <= vl_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_rvv_backend_alu_mask_viota_seq.sv
// Directed and randomized checks of the viota/vcpop sequencer against a global prefix-count model.
module tb_rvv_backend_alu_mask_viota_seq;
    import rvv_backend_pkg::*;

    localparam int VLEN   = 512;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 10;
    localparam int VL_W   = 10;
    localparam int BEAT_W = 3;

    typedef logic [639:0] w_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [VLEN-1:0]   cmd_vs2 = '0;
    logic [VLEN-1:0]   cmd_v0 = '0;
    logic              cmd_vm = 1'b0;
    logic [VL_W-1:0]   cmd_vl = '0;
    logic [TAG_W-1:0]  cmd_tag = '0;
    logic              beat_valid;
    logic              beat_ready = 1'b0;
    logic [BEAT_W-1:0] beat_idx;
    logic [64*CNT_W-1:0] beat_result;
    logic [63:0]       beat_elem_en;
    logic              beat_last;
    logic [CNT_W-1:0]  beat_total;
    logic [TAG_W-1:0]  beat_tag;
    logic              busy;

    int checks = 0;
    int failures = 0;

    logic [VLEN-1:0]  m_vs2, m_v0;
    logic             m_vm;
    int               m_vl;
    logic [TAG_W-1:0] m_tag;

    always #5 clk = ~clk;

    rvv_backend_alu_mask_viota_seq #(.VLEN(VLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vs2(cmd_vs2), .cmd_v0(cmd_v0),
        .cmd_vm(cmd_vm), .cmd_vl(cmd_vl), .cmd_tag(cmd_tag),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_idx(beat_idx),
        .beat_result(beat_result), .beat_elem_en(beat_elem_en), .beat_last(beat_last),
        .beat_total(beat_total), .beat_tag(beat_tag), .busy(busy)
    );

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbeats();
        return (m_vl == 0) ? 1 : (m_vl + 63) / 64;
    endfunction

    // Reference: count of active elements strictly below each global index, computed over the whole register.
    function automatic void model_beat(input int b, output logic [63:0] en,
                                       output logic [64*CNT_W-1:0] res, output viota_cnt_t total);
        int   cnt;
        logic e;
        cnt = 0;
        en  = '0;
        res = '0;
        for (int g = 0; g < VLEN; g++) begin
            e = (g < m_vl) && (m_vm || m_v0[g]);
            if (g / 64 == b) begin
                en[g % 64] = e;
                res[(g % 64)*CNT_W +: CNT_W] = CNT_W'(cnt);
            end
            if (e && m_vs2[g]) cnt++;
        end
        total = CNT_W'(cnt);
    endfunction

    function automatic logic [VLEN-1:0] rand512();
        logic [VLEN-1:0] r;
        for (int k = 0; k < VLEN/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [VLEN-1:0] vs2, input logic [VLEN-1:0] v0,
                        input logic vm, input int vl, input logic [TAG_W-1:0] tag);
        int n;
        m_vs2 = vs2; m_v0 = v0; m_vm = vm; m_vl = vl; m_tag = tag;
        cmd_vs2 = vs2; cmd_v0 = v0; cmd_vm = vm; cmd_vl = VL_W'(vl); cmd_tag = tag;
        cmd_valid = 1'b1;
        n = 0;
        #1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("cmd_accept", w_t'(cmd_ready), w_t'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int pct, input int stall_beat, input int stall_len);
        int b, n, stalled;
        logic was_stall;
        logic [63:0] en;
        logic [64*CNT_W-1:0] res;
        viota_cnt_t tot;
        logic [64*CNT_W-1:0] s_res;
        logic [82:0] s_ctl;
        b = 0; n = 0; stalled = 0; was_stall = 1'b0;
        s_res = '0; s_ctl = '0;
        while (b < nbeats() && n < 2000) begin
            if (b == stall_beat && stalled < stall_len) begin
                beat_ready = 1'b0;
                stalled++;
            end else begin
                beat_ready = ($urandom_range(0, 99) < pct);
            end
            #1;
            if (was_stall) begin
                chk("stall_valid", w_t'(beat_valid), w_t'(1));
                chk("stall_result", w_t'(beat_result), w_t'(s_res));
                chk("stall_ctl", w_t'({beat_idx, beat_elem_en, beat_last, beat_tag, beat_total}), w_t'(s_ctl));
            end
            was_stall = 1'b0;
            if (beat_valid) begin
                if (beat_ready) begin
                    model_beat(b, en, res, tot);
                    chk("beat_idx", w_t'(beat_idx), w_t'(b));
                    chk("elem_en", w_t'(beat_elem_en), w_t'(en));
                    chk("result", w_t'(beat_result), w_t'(res));
                    chk("last", w_t'(beat_last), w_t'(b == nbeats() - 1));
                    chk("tag", w_t'(beat_tag), w_t'(m_tag));
                    if (b == nbeats() - 1) chk("total", w_t'(beat_total), w_t'(tot));
                    b++;
                end else begin
                    was_stall = 1'b1;
                    s_res = beat_result;
                    s_ctl = {beat_idx, beat_elem_en, beat_last, beat_tag, beat_total};
                end
            end
            @(negedge clk);
            n++;
        end
        beat_ready = 1'b0;
        chk("beat_count", w_t'(b), w_t'(nbeats()));
    endtask

    initial begin
        logic [VLEN-1:0] ones, v55;
        ones = '1;
        v55  = {8{64'h5555_5555_5555_5555}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", w_t'(beat_valid), w_t'(0));
        chk("rst_busy", w_t'(busy), w_t'(0));
        chk("rst_cmd_ready", w_t'(cmd_ready), w_t'(1));
        chk("rst_total", w_t'(beat_total), w_t'(0));
        chk("rst_result", w_t'(beat_result), w_t'(0));
        rst_n = 1'b1;
        @(negedge clk);

        send(512'h3FF, '0, 1'b1, 10, 5'd1);
        collect(100, -1, 0);

        send(ones, '0, 1'b1, 130, 5'd2);
        collect(100, -1, 0);

        send(ones, v55, 1'b0, 64, 5'd3);
        collect(100, -1, 0);

        send(ones, '0, 1'b1, 512, 5'd4);
        collect(100, 3, 5);

        // Flush in the middle of a long command; a command offered alongside must be refused.
        send(ones, '0, 1'b1, 512, 5'd7);
        beat_ready = 1'b1;
        @(negedge clk);
        beat_ready = 1'b0;
        #1;
        chk("flush_pre_idx", w_t'(beat_idx), w_t'(1));
        flush = 1'b1;
        cmd_valid = 1'b1;
        cmd_vl = VL_W'(9);
        #1;
        chk("flush_cmd_ready", w_t'(cmd_ready), w_t'(0));
        @(negedge clk);
        flush = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("flush_valid", w_t'(beat_valid), w_t'(0));
        chk("flush_busy", w_t'(busy), w_t'(0));
        chk("flush_cmd_ready_after", w_t'(cmd_ready), w_t'(1));
        @(negedge clk);
        send(512'hF, '0, 1'b1, 4, 5'd8);
        collect(100, -1, 0);

        // Zero-bubble handover: B offered in A's last-beat handshake cycle.
        send(ones, '0, 1'b1, 64, 5'd3);
        beat_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_vm = 1'b1;
        cmd_vl = '0;
        cmd_tag = 5'd12;
        #1;
        chk("b2b_a_last", w_t'(beat_last), w_t'(1));
        chk("b2b_a_total", w_t'(beat_total), w_t'(64));
        chk("b2b_cmd_ready", w_t'(cmd_ready), w_t'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        beat_ready = 1'b0;
        m_vl = 0; m_vm = 1'b1; m_tag = 5'd12;
        #1;
        chk("b2b_b_valid", w_t'(beat_valid), w_t'(1));
        @(negedge clk);
        collect(100, -1, 0);

        for (int t = 0; t < 40; t++) begin
            int vl;
            case ($urandom_range(0, 9))
                0:       vl = 0;
                1:       vl = 512;
                2:       vl = 64 * $urandom_range(1, 8);
                default: vl = $urandom_range(0, 512);
            endcase
            send(rand512(), rand512(), 1'($urandom_range(0, 1)), vl, TAG_W'($urandom));
            collect(60, $urandom_range(0, 7), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
